// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the NxN systolic-array controller.
//   - state encoding for the controller FSM
//   - skew_idx(): operand index k = t - lane and its valid flag
//   - bytes_per_elem(): result bytes emitted per accumulator
// Optional feature macro: SYSTOLIC_SAT_OUT_EN (one saturated byte per element).
package systolic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_COMPUTE = 3'd2;
  localparam state_t ST_SNAP    = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

  typedef struct packed {
    logic [7:0] k;
    logic       vld;
  } skew_t;

  // Lane 'lane' sees operand k = t - lane; it is valid only while 0 <= k < n.
  // An invalid lane reports k = 0 so the array sees a quiet select.
  function automatic skew_t skew_idx(input int t, input int lane, input int n);
    skew_t r;
    int    k;
    k     = t - lane;
    r.vld = (k >= 0) && (k < n);
    r.k   = r.vld ? k[7:0] : 8'd0;
    return r;
  endfunction

  function automatic int bytes_per_elem(input int aw);
`ifdef SYSTOLIC_SAT_OUT_EN
    return (aw > 0) ? 1 : 1;
`else
    return aw / 8;
`endif
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// systolic_skew_gen: registered skewed operand selects for N lanes (rows or
// columns). The inputs describe the *next* cycle (en = next cycle is a compute
// cycle, t = its index) so the registered outputs line up with feed_valid.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : next cycle is a compute cycle
//   t        : compute cycle index of the next cycle
//   sel      : per-lane k index, lane i at [i*SELW +: SELW]
//   vld      : per-lane operand valid
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int N    = 2,
  parameter int SELW = 1,
  parameter int TW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TW-1:0]     t,
  output logic [N*SELW-1:0] sel,
  output logic [N-1:0]      vld
);

  skew_t                  sk [N];
  logic [N*SELW-1:0]      sel_d;
  logic [N-1:0]           vld_d;
  logic [N*(8-SELW)-1:0]  k_hi;
  logic                   unused_k;

  always_comb begin
    sel_d = '0;
    vld_d = '0;
    k_hi  = '0;
    for (int i = 0; i < N; i++) begin
      sk[i] = skew_idx(int'(t), i, N);
      k_hi[i*(8-SELW) +: (8-SELW)] = sk[i].k[7:SELW];
      if (en) begin
        sel_d[i*SELW +: SELW] = sk[i].k[SELW-1:0];
        vld_d[i]              = sk[i].vld;
      end
    end
  end

  // k never exceeds N-1, so the bits above SELW are always zero.
  assign unused_k = ^k_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
      vld <= '0;
    end else begin
      sel <= sel_d;
      vld <= vld_d;
    end
  end

endmodule

// File: rtl/systolic_ctrl_nxn.sv
// systolic_ctrl_nxn: control unit for an NxN operand-streaming systolic array.
// Loads N*N weights then N*N inputs into operand memory, runs a 3N-2 cycle
// skewed compute phase, snapshots the accumulators and streams them out
// row-major, MSB byte first, over a valid/ready byte interface.
// Optional feature macro: SYSTOLIC_SAT_OUT_EN -- when defined, each element is
// saturated to a signed byte and emitted as a single byte.
//
// Handshakes: a byte moves on a cycle where valid && ready are both high at the
// clock edge. The producer holds data stable while valid && !ready; ready never
// depends on the same-cycle valid.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready/in_data, transpose : host operand byte stream
//   mem_we/mem_addr/mem_wdata: operand memory write port (registered)
//   clear, feed_valid       : accumulator clear / compute-phase strobe
//   a_sel/a_vld, b_sel/b_vld: skewed per-row / per-column operand selects
//   transpose_out           : latched transpose flag for B addressing
//   c_flat                  : accumulators, PE(r,c) at [(r*N+c)*AW +: AW]
//   out_valid/out_ready/out_data : result byte stream
//   done                    : pulses with the final result handshake
module systolic_ctrl_nxn
  import systolic_pkg::*;
#(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int SELW = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int MAW  = $clog2(2*N*N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              transpose,
  output logic              mem_we,
  output logic [MAW-1:0]    mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              clear,
  output logic              feed_valid,
  output logic [N*SELW-1:0] a_sel,
  output logic [N-1:0]      a_vld,
  output logic [N*SELW-1:0] b_sel,
  output logic [N-1:0]      b_vld,
  output logic              transpose_out,
  input  logic [N*N*AW-1:0] c_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              done
);

  localparam int NN        = N * N;
  localparam int LAST_ADDR = 2 * NN - 1;
  localparam int TW        = $clog2(3 * N);
  localparam int T_LAST    = 3 * N - 3;
  localparam int BPE       = bytes_per_elem(AW);
  localparam int EW        = $clog2(NN);
  localparam int BW        = (BPE > 1) ? $clog2(BPE) : 1;

  state_t              state;
  state_t              state_next;
  logic [MAW-1:0]      load_addr;
  logic [TW-1:0]       t;
  logic [TW-1:0]       t_next;
  logic [N*N*AW-1:0]   snap;
  logic [EW-1:0]       elem_idx;
  logic [BW-1:0]       byte_idx;
  logic [AW-1:0]       elem;
  logic                hs;
  logic                load_last;
  logic                t_last;
  logic                out_hs;
  logic                byte_last;
  logic                elem_last;
  logic                drain_last;

  assign hs         = in_valid && in_ready;
  assign load_last  = (load_addr == MAW'(LAST_ADDR));
  assign t_last     = (t == TW'(T_LAST));
  assign out_hs     = (state == ST_DRAIN) && out_ready;
  assign byte_last  = (byte_idx == BW'(BPE - 1));
  assign elem_last  = (elem_idx == EW'(NN - 1));
  assign drain_last = out_hs && byte_last && elem_last;
  // The compute index counts only while in COMPUTE and restarts at 0 otherwise.
  assign t_next     = (state == ST_COMPUTE) ? t + 1'b1 : '0;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (hs) state_next = ST_LOAD;
      ST_LOAD:    if (hs && load_last) state_next = ST_COMPUTE;
      ST_COMPUTE: if (t_last) state_next = ST_SNAP;
      ST_SNAP:    state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_last) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready   = 1'b0;
    feed_valid = 1'b0;
    clear      = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: in_ready = 1'b1;
      ST_COMPUTE: begin
        feed_valid = 1'b1;
        clear      = (t == '0);
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        done      = drain_last;
      end
      default: ;
    endcase
  end

  // ---------------- load, compute counter, snapshot, drain counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr     <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      transpose_out <= 1'b0;
      t             <= '0;
      snap          <= '0;
      elem_idx      <= '0;
      byte_idx      <= '0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_addr  <= load_addr;
        mem_wdata <= in_data;
        load_addr <= load_last ? '0 : load_addr + 1'b1;
      end
      if (hs && (state == ST_IDLE)) transpose_out <= transpose;
      t <= t_next;
      if (state == ST_SNAP) begin
        snap     <= c_flat;
        elem_idx <= '0;
        byte_idx <= '0;
      end else if (out_hs) begin
        if (byte_last) begin
          byte_idx <= '0;
          // Wrap to 0 after the last element so the select stays in range.
          elem_idx <= elem_last ? '0 : elem_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // ---------------- result byte select ----------------
`ifdef SYSTOLIC_SAT_OUT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
  localparam logic signed [AW-1:0] SAT_MIN = -AW'(128);

  always_comb begin
    elem = snap[int'(elem_idx)*AW +: AW];
    if ($signed(elem) > SAT_MAX)      out_data = 8'h7F;
    else if ($signed(elem) < SAT_MIN) out_data = 8'h80;
    else                              out_data = elem[7:0];
  end
`else
  always_comb begin
    elem     = snap[int'(elem_idx)*AW +: AW];
    // byte_idx 0 is the most significant byte of the element.
    out_data = elem[(BPE-1-int'(byte_idx))*8 +: 8];
  end
`endif

  // ---------------- skewed operand selects ----------------
  systolic_skew_gen #(.N(N), .SELW(SELW), .TW(TW)) u_row_skew (
    .clk (clk),
    .rst (rst),
    .en  (state_next == ST_COMPUTE),
    .t   (t_next),
    .sel (a_sel),
    .vld (a_vld)
  );

  systolic_skew_gen #(.N(N), .SELW(SELW), .TW(TW)) u_col_skew (
    .clk (clk),
    .rst (rst),
    .en  (state_next == ST_COMPUTE),
    .t   (t_next),
    .sel (b_sel),
    .vld (b_vld)
  );

endmodule

// File: tb/tb_systolic_ctrl_nxn.sv
// tb_systolic_ctrl_nxn: directed bench for systolic_ctrl_nxn (N=2 main
// instance, N=3 instance for the skew check). Build with SYSTOLIC_SAT_OUT_EN
// defined to exercise the saturated one-byte-per-element drain.
module tb_systolic_ctrl_nxn;

`ifdef SYSTOLIC_SAT_OUT_EN
  localparam int BPE_TB = 1;
`else
  localparam int BPE_TB = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=2 instance ----------------
  logic        in_valid = 1'b0, in_ready, transpose = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        clear, feed_valid, transpose_out;
  logic [1:0]  a_sel, a_vld, b_sel, b_vld;
  logic [63:0] c_flat;
  logic        out_valid, out_ready = 1'b0, done;
  logic [7:0]  out_data;

  systolic_ctrl_nxn #(.N(2), .DW(8), .AW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .transpose(transpose), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .clear(clear), .feed_valid(feed_valid), .a_sel(a_sel), .a_vld(a_vld),
    .b_sel(b_sel), .b_vld(b_vld), .transpose_out(transpose_out), .c_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
  );

  // ---------------- N=3 instance ----------------
  logic         in_valid3 = 1'b0, in_ready3;
  logic [7:0]   in_data3 = 8'h00;
  logic         mem_we3;
  logic [4:0]   mem_addr3;
  logic [7:0]   mem_wdata3;
  logic         clear3, feed_valid3, transpose_out3;
  logic [5:0]   a_sel3, b_sel3;
  logic [2:0]   a_vld3, b_vld3;
  logic [143:0] c_flat3 = '0;
  logic         out_valid3, out_ready3 = 1'b0, done3;
  logic [7:0]   out_data3;

  systolic_ctrl_nxn #(.N(3), .DW(8), .AW(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .transpose(1'b0), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .clear(clear3), .feed_valid(feed_valid3), .a_sel(a_sel3), .a_vld(a_vld3),
    .b_sel(b_sel3), .b_vld(b_vld3), .transpose_out(transpose_out3), .c_flat(c_flat3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .done(done3)
  );

  // ---------------- array model: C = W * X (or W * X^T) ----------------
  logic [7:0]  w_m [4];
  logic [7:0]  x_m [4];
  logic        tr_m = 1'b0;
  logic        ovr = 1'b0;
  logic [15:0] ovr_c [4];

  always_comb begin
    int acc;
    c_flat = '0;
    acc    = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        acc = 0;
        for (int k = 0; k < 2; k++)
          acc += int'(w_m[r*2+k]) * int'(tr_m ? x_m[c*2+k] : x_m[k*2+c]);
        c_flat[(r*2+c)*16 +: 16] = ovr ? ovr_c[r*2+c] : acc[15:0];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic        tr;
    logic        gap;
    logic        alt;
    logic [63:0] exp_full;
    logic [31:0] exp_sat;
  } vec_t;
  vec_t vecs [3];

  logic [1:0] exp_vld [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] exp_sel [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

  task automatic push_expected(input logic [63:0] full, input logic [31:0] sat);
    if (BPE_TB == 1) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(sat[31-8*i -: 8]);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back(full[63-8*i -: 8]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Loads bytes 1..8; transpose is only meaningful on the first byte.
  task automatic load2(input logic tr, input logic gap);
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 3) begin
        in_valid = 1'b0;
        step();
        chk("gap_no_write", mem_we, 1'b0);
        chk("gap_ready", in_ready, 1'b1);
      end
      in_valid  = 1'b1;
      in_data   = 8'(i + 1);
      transpose = (i == 0) ? tr : ~tr;
      if (i < 4) w_m[i] = 8'(i + 1);
      else       x_m[i-4] = 8'(i + 1);
      chk("load_ready", in_ready, 1'b1);
      step();
      chk("mem_we", mem_we, 1'b1);
      chk("mem_addr", mem_addr, i);
      chk("mem_wdata", mem_wdata, i + 1);
    end
    tr_m     = tr;
    in_valid = 1'b0;
  endtask

  // Entered one step after the final load handshake (first COMPUTE cycle).
  // in_valid is held high to show that compute ignores it.
  task automatic compute2(input logic tr);
    int cyc;
    cyc      = 0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    while (feed_valid === 1'b1 && cyc < 12) begin
      if (cyc < 4) begin
        chk("a_vld", a_vld, exp_vld[cyc]);
        chk("a_sel", a_sel, exp_sel[cyc]);
        chk("b_vld", b_vld, exp_vld[cyc]);
        chk("b_sel", b_sel, exp_sel[cyc]);
        chk("clear", clear, cyc == 0);
        chk("compute_ready", in_ready, 1'b0);
        chk("transpose_out", transpose_out, tr);
        if (cyc > 0) chk("compute_no_write", mem_we, 1'b0);
      end
      cyc++;
      step();
    end
    chk("compute_len", cyc, 4);
    chk("snap_out_valid", out_valid, 1'b0);
    chk("snap_feed_valid", feed_valid, 1'b0);
  endtask

  // Drains exp_q; alt=1 toggles out_ready 1,0,1,0...
  task automatic drain2(input logic alt);
    int         guard;
    logic       stalled;
    logic [7:0] held;
    guard   = 0;
    stalled = 1'b0;
    held    = 8'h00;
    while (exp_q.size() > 0 && guard < 200) begin
      out_ready = alt ? ((guard % 2) == 0) : 1'b1;
      @(negedge clk);
      chk("drain_no_write", mem_we, 1'b0);
      if (out_valid) begin
        chk("out_data", out_data, exp_q[0]);
        if (stalled) chk("held_data", out_data, held);
        if (out_ready) begin
          void'(exp_q.pop_front());
          chk("done", done, exp_q.size() == 0);
          stalled = 1'b0;
        end else begin
          held    = out_data;
          stalled = 1'b1;
          chk("done_stall", done, 1'b0);
        end
      end else begin
        chk("done_quiet", done, 1'b0);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d bytes left required 0", exp_q.size());
      exp_q.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'h0013_0016_002B_0032, 32'h13_16_2B_32};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 64'h0011_0017_0027_0035, 32'h11_17_27_35};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0013_0016_002B_0032, 32'h13_16_2B_32};
    for (int i = 0; i < 4; i++) begin
      w_m[i]   = 8'h00;
      x_m[i]   = 8'h00;
      ovr_c[i] = 16'h0000;
    end

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_clear", clear, 1'b0);
    chk("rst_feed", feed_valid, 1'b0);
    chk("rst_sel", {a_sel, a_vld, b_sel, b_vld}, 0);
    chk("rst_tr", transpose_out, 1'b0);
    chk("rst_out", {out_valid, out_data, done}, 0);

    // Table-driven full transactions.
    for (int v = 0; v < 3; v++) begin
      load2(vecs[v].tr, vecs[v].gap);
      compute2(vecs[v].tr);
      push_expected(vecs[v].exp_full, vecs[v].exp_sat);
      drain2(vecs[v].alt);
    end

    // Reset mid-load, coinciding with a valid byte destined for address 5.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      step();
    end
    chk("pre_rst_addr", mem_addr, 4);
    in_data = 8'h45;
    rst     = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_load_no_write", mem_we, 1'b0);
    chk("rst_load_ready", in_ready, 1'b1);
    chk("rst_load_addr", mem_addr, 0);
    load2(1'b0, 1'b0);
    compute2(1'b0);
    push_expected(vecs[0].exp_full, vecs[0].exp_sat);
    drain2(1'b0);

    // Reset mid-drain aborts the stream.
    load2(1'b0, 1'b0);
    compute2(1'b0);
    out_ready = 1'b1;
    step();
    chk("mid_drain_valid", out_valid, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("rst_drain_valid", out_valid, 1'b0);
    chk("rst_drain_ready", in_ready, 1'b1);
    chk("rst_drain_done", done, 1'b0);

    // Large / negative accumulators: C00=300, C01=5, C10=-3, C11=-200.
    ovr      = 1'b1;
    ovr_c[0] = 16'h012C;
    ovr_c[1] = 16'h0005;
    ovr_c[2] = 16'hFFFD;
    ovr_c[3] = 16'hFF38;
    load2(1'b0, 1'b0);
    compute2(1'b0);
    push_expected(64'h012C_0005_FFFD_FF38, 32'h7F_05_FD_80);
    drain2(1'b1);
    ovr = 1'b0;

    // N=3 skew check.
    begin
      int cyc;
      int nbytes;
      int guard;
      logic got_done;
      for (int i = 0; i < 18; i++) begin
        in_valid3 = 1'b1;
        in_data3  = 8'(i);
        step();
      end
      in_valid3 = 1'b0;
      chk("n3_last_addr", mem_addr3, 17);
      cyc = 0;
      while (feed_valid3 === 1'b1 && cyc < 20) begin
        if (cyc == 2) begin
          chk("n3_a_vld_t2", a_vld3, 3'b111);
          chk("n3_a_sel_t2", a_sel3, 6'b00_01_10);
          chk("n3_b_vld_t2", b_vld3, 3'b111);
        end
        if (cyc == 6) begin
          chk("n3_a_vld_t6", a_vld3, 3'b000);
          chk("n3_b_vld_t6", b_vld3, 3'b000);
        end
        cyc++;
        step();
      end
      chk("n3_compute_len", cyc, 7);
      out_ready3 = 1'b1;
      nbytes     = 0;
      guard      = 0;
      got_done   = 1'b0;
      while (!got_done && guard < 100) begin
        @(negedge clk);
        if (out_valid3) begin
          chk("n3_out_data", out_data3, 8'h00);
          nbytes++;
        end
        got_done = done3;
        step();
        guard++;
      end
      out_ready3 = 1'b0;
      chk("n3_done_seen", got_done, 1'b1);
      chk("n3_byte_count", nbytes, 9 * BPE_TB);
      chk("n3_idle_ready", in_ready3, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_ctrl_nxn.md
Name: systolic_ctrl_nxn

Overview:
- Parametrised successor to the 2x2 systolic-array control unit; sequences an NxN weight-stationary-free (operand-streaming) array.
- Accepts a byte stream of N*N weights then N*N inputs into operand memory, generates skewed per-row/per-column operand selects, and snapshots the accumulators.
- Streams results to the host over a valid/ready byte interface.
- Sits between the host shim, the operand memory and the systolic array.

Parameters:
- N, 2, array dimension; legal range 2..8.
- DW, 8, operand width written to memory.
- AW, 16, accumulator width per PE; must be a multiple of 8.
- SELW, $clog2(N) with minimum 1, width of each operand-index select.
- MAW, $clog2(2*N*N), operand memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host operand byte valid.
- in_ready  out  1  block accepts an operand byte this cycle.
- in_data  in  DW  operand byte; passed through as mem_wdata.
- transpose  in  1  use B transposed; sampled on the first accepted byte of a load.
- mem_we  out  1  operand memory write enable.
- mem_addr  out  MAW  write address. Weights occupy 0..N*N-1; inputs occupy N*N..2N*N-1.
- mem_wdata  out  DW  registered copy of in_data.
- clear  out  1  one-cycle accumulator clear, asserted on the first COMPUTE cycle.
- feed_valid  out  1  high for the whole of COMPUTE.
- a_sel  out  N*SELW  per-row k index; row i occupies slice [i*SELW +: SELW].
- a_vld  out  N  per-row operand valid; a zero operand is fed when low.
- b_sel  out  N*SELW  per-column k index.
- b_vld  out  N  per-column operand valid.
- transpose_out  out  1  latched transpose for the array's B addressing.
- c_flat  in  N*N*AW  accumulators, row-major; PE(r,c) occupies [(r*N+c)*AW +: AW].
- out_valid  out  1  result byte valid.
- out_ready  in  1  host accepts result byte.
- out_data  out  8  result byte.
- done  out  1  one-cycle pulse when the last result byte handshakes.

Behaviour:
- States: IDLE, LOAD, COMPUTE, SNAP, DRAIN. Reset puts the block in IDLE.
- Reset values: all outputs 0, except in_ready=1 (IDLE is ready). Internal counters and the snapshot register are cleared.
- IDLE: in_ready=1. The first in_valid&&in_ready writes address 0, latches transpose, and moves to LOAD.
- LOAD: in_ready=1. Each handshake writes mem_addr, then increments it.
  - mem_we and mem_wdata are registered and track in_valid&&in_ready with 1-cycle latency.
  - Gaps in in_valid stall the load without error.
  - The handshake at address 2N*N-1 moves to COMPUTE and wraps the address to 0.
- COMPUTE: lasts exactly 3N-2 cycles, t = 0..3N-3. in_ready=0; in_valid is ignored and nothing is written.
  - For row i: k = t-i. a_vld[i] = (0 <= k < N); a_sel[i] = k when valid, else 0. Columns use the same rule.
  - Selects are registered and align with feed_valid.
  - clear is high only at t=0.
- SNAP: one cycle. c_flat is registered into the snapshot; the array may then be overwritten.
- DRAIN: emits N*N*(AW/8) bytes, element order row-major, MSB byte first.
  - out_data is held stable while out_valid && !out_ready.
  - After the final handshake, done pulses for one cycle and the next state is IDLE.
  - in_ready stays 0 until IDLE; bytes offered early are not accepted.
- Boundaries:
  - Reset mid-load or mid-drain aborts immediately. Partial memory contents are don't-care; the next load restarts at address 0.
  - Simultaneous in_valid and reset: reset wins, no write.
  - out_ready held high gives back-to-back bytes.

Optional Feature:
- Macro SYSTOLIC_SAT_OUT_EN.
- Defined: DRAIN emits one byte per element (N*N bytes). Each AW-bit signed value is saturated to [-128, 127].
- Undefined: full-width multi-byte output as described above.

Decomposition:
- Package systolic_pkg holds:
  - state encoding localparams;
  - helper function for the skew index, returning k and its valid;
  - BYTES_PER_ELEM derivation.
- Sub-module systolic_skew_gen: combinational/registered generation of a_sel, a_vld, b_sel, b_vld from t, instanced for both rows and columns.
- The FSM, load counter and drain serializer stay in the top module.

Test Plan:
- N=2, load 1,2,3,4,5,6,7,8 back to back with the bench model supplying C=W*X. Expect mem writes to addresses 0..7, then a 4-cycle COMPUTE with clear at t=0, then bytes 00 13 00 16 00 2B 00 32 and one done pulse.
- Same stimulus with transpose=1. Expect bytes 00 11 00 17 00 27 00 35 and transpose_out=1 throughout.
- N=3 skew check. At t=2 expect a_vld=111, a_sel rows = 2,1,0. At t=6 expect a_vld=000. COMPUTE lasts 7 cycles.
- Toggle out_ready 1010... during DRAIN. out_data is held while stalled, byte order is unchanged, and done fires exactly on the last handshake.
- Assert rst when the load is at address 5, then reload 8 bytes. Expect the first write at address 0 and normal results.
- Define SYSTOLIC_SAT_OUT_EN and model C00=300, C11=-200. Expect a 4-byte drain with 7F as first byte and 80 as last byte.
